// File: rtl/vehicle_sensor.sv
// Side-road vehicle detector: synchronizes the loop input, debounces it, holds the request, flags a stuck sensor.
// Optional saturating vehicle counter enabled by defining VEHICLE_SENSOR_COUNT_EN.
//
// state   | meaning
// IDLE    | no vehicle, waiting for the synchronized sensor to go high
// QUAL    | sensor high, debouncing before the vehicle is accepted
// PRESENT | vehicle qualified and still on the loop
// HOLD    | sensor dropped, request held for HOLD_CYC cycles
// FAULT   | sensor high too long, treated as stuck until it goes low
module vehicle_sensor #(
  parameter int DEBOUNCE_CYC = 4,
  parameter int HOLD_CYC     = 8,
  parameter int STUCK_CYC    = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       raw_sensor,
  output logic       car_req,
  output logic       det_pulse,
  output logic       fault,
  output logic [7:0] car_count
);

  typedef enum logic [2:0] {IDLE, QUAL, PRESENT, HOLD, FAULT} state_e;

  localparam logic [7:0] DEB_LAST   = 8'(DEBOUNCE_CYC - 1);
  localparam logic [7:0] HOLD_LAST  = 8'(HOLD_CYC - 1);
  localparam logic [7:0] STUCK_LAST = 8'(STUCK_CYC - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       s1_q, s2_q;
  logic       car_req_q, det_pulse_q, fault_q;
  logic       det_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= raw_sensor;
      s2_q <= s1_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      car_req_q   <= 1'b0;
      det_pulse_q <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      car_req_q   <= (state_d == PRESENT) || (state_d == HOLD);
      det_pulse_q <= det_d;
      fault_q     <= (state_d == FAULT);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    det_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (s2_q) begin
          state_d = QUAL;
          cnt_d   = 8'd0;
        end
      end
      QUAL: begin
        if (!s2_q) begin
          state_d = IDLE;
        end else if (cnt_q == DEB_LAST) begin
          state_d = PRESENT;
          cnt_d   = 8'd0;
          det_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      PRESENT: begin
        if (!s2_q) begin
          state_d = HOLD;
          cnt_d   = 8'd0;
        end else if (cnt_q == STUCK_LAST) begin
          state_d = FAULT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      HOLD: begin
        // Returning vehicle goes straight back to PRESENT without a new detection pulse.
        if (s2_q) begin
          state_d = PRESENT;
          cnt_d   = 8'd0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      FAULT: begin
        if (!s2_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign car_req   = car_req_q;
  assign det_pulse = det_pulse_q;
  assign fault     = fault_q;

`ifdef VEHICLE_SENSOR_COUNT_EN
  logic [7:0] car_count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      car_count_q <= 8'd0;
    end else if (det_d && (car_count_q != 8'hFF)) begin
      car_count_q <= car_count_q + 8'd1;
    end
  end

  assign car_count = car_count_q;
`else
  assign car_count = 8'd0;
`endif

endmodule

// File: tb/tb_vehicle_sensor.sv
// Self-checking bench for vehicle_sensor: run-length reference model, per-cycle compare, directed latency checks.
module tb_vehicle_sensor;

  localparam int DEB   = 4;
  localparam int HOLD  = 8;
  localparam int STUCK = 200;
`ifdef VEHICLE_SENSOR_COUNT_EN
  localparam bit COUNT_EN = 1'b1;
`else
  localparam bit COUNT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       raw_sensor = 1'b0;
  logic       car_req, det_pulse, fault;
  logic [7:0] car_count;

  int total = 0;
  int bad   = 0;

  vehicle_sensor #(.DEBOUNCE_CYC(DEB), .HOLD_CYC(HOLD), .STUCK_CYC(STUCK)) dut (
    .clk(clk), .rst(rst), .raw_sensor(raw_sensor),
    .car_req(car_req), .det_pulse(det_pulse), .fault(fault), .car_count(car_count)
  );

  always #10 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks sampled-raw history and run lengths of what the detector logic sees.
  bit m_r1, m_r2, m_req, m_flt, m_pulse;
  int m_hi, m_lo, m_pres, m_cnt;

  always @(posedge clk or negedge rst) begin : model
    bit v, rq, fl, pl;
    int h, l, p, c;
    if (!rst) begin
      m_r1 <= 0; m_r2 <= 0; m_req <= 0; m_flt <= 0; m_pulse <= 0;
      m_hi <= 0; m_lo <= 0; m_pres <= 0; m_cnt <= 0;
    end else begin
      v = m_r2; rq = m_req; fl = m_flt; pl = 0;
      h = m_hi; l = m_lo; p = m_pres; c = m_cnt;
      if (fl) begin
        if (!v) begin fl = 0; h = 0; end
      end else if (rq) begin
        if (v) begin
          if (l > 0) begin p = 0; l = 0; end
          else begin
            p++;
            if (p == STUCK) begin fl = 1; rq = 0; end
          end
        end else begin
          l++;
          if (l == HOLD + 1) begin rq = 0; l = 0; h = 0; end
        end
      end else begin
        if (v) begin
          h++;
          if (h == DEB + 1) begin
            rq = 1; pl = 1; p = 0; l = 0; h = 0;
            if (COUNT_EN && c < 255) c++;
          end
        end else h = 0;
      end
      m_r2 <= m_r1; m_r1 <= raw_sensor;
      m_req <= rq; m_flt <= fl; m_pulse <= pl;
      m_hi <= h; m_lo <= l; m_pres <= p; m_cnt <= c;
    end
  end

  always @(negedge clk) begin
    chk("car_req", car_req, m_req);
    chk("det_pulse", det_pulse, m_pulse);
    chk("fault", fault, m_flt);
    chk("car_count", car_count, m_cnt);
  end

  task automatic vehicle(input int hi_n, input int lo_n);
    @(negedge clk) raw_sensor = 1'b1;
    repeat (hi_n) @(negedge clk);
    raw_sensor = 1'b0;
    repeat (lo_n) @(negedge clk);
  endtask

  initial begin
    // Reset with sensor already high: everything quiet, then qualification at edge 7.
    raw_sensor = 1'b1;
    #5;
    chk("rst_car_req", car_req, 0);
    chk("rst_det", det_pulse, 0);
    chk("rst_fault", fault, 0);
    chk("rst_count", car_count, 0);
    #7 rst = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk); #1;
      chk("rise_edge_car_req", car_req, (e >= 7));
      chk("rise_edge_det", det_pulse, (e == 7));
    end

    // Re-presence during HOLD keeps the request up, then release falls at edge 11.
    @(negedge clk) raw_sensor = 1'b0;
    repeat (4) @(negedge clk);
    raw_sensor = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("rehold_car_req", car_req, 1);
      chk("rehold_det", det_pulse, 0);
    end
    raw_sensor = 1'b0;
    for (int e = 1; e <= 11; e++) begin
      @(posedge clk); #1;
      chk("fall_edge_car_req", car_req, (e < 11));
    end

    // Short pulse never qualifies.
    repeat (5) @(negedge clk);
    raw_sensor = 1'b1;
    repeat (3) @(negedge clk);
    raw_sensor = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("short_car_req", car_req, 0);
      chk("short_det", det_pulse, 0);
      chk("short_fault", fault, 0);
    end

    // Stuck sensor.
    raw_sensor = 1'b1;
    repeat (215) @(negedge clk);
    chk("stuck_fault", fault, 1);
    chk("stuck_car_req", car_req, 0);
    raw_sensor = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      @(posedge clk); #1;
      chk("fault_clear_edge", fault, (e < 3));
    end

    // Reset in HOLD drops the request immediately; requalification takes 7 edges.
    repeat (5) @(negedge clk);
    raw_sensor = 1'b1;
    repeat (10) @(negedge clk);
    raw_sensor = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_rst_hold_car_req", car_req, 1);
    #3 rst = 1'b0;
    #1;
    chk("async_rst_car_req", car_req, 0);
    chk("async_rst_fault", fault, 0);
    raw_sensor = 1'b1;
    @(negedge clk) rst = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      @(posedge clk); #1;
      chk("requal_edge_car_req", car_req, (e >= 7));
    end

    // Vehicle counter: 3 then saturation.
    @(negedge clk) raw_sensor = 1'b0;
    repeat (15) @(negedge clk);
    #3 rst = 1'b0;
    #4 rst = 1'b1;
    for (int i = 0; i < 3; i++) vehicle(8, 14);
    chk("count_3", car_count, COUNT_EN ? 3 : 0);
    for (int i = 0; i < 257; i++) vehicle(8, 14);
    chk("count_sat", car_count, COUNT_EN ? 255 : 0);

    // Randomized run lengths with occasional stuck runs and reset pulses.
    for (int s = 0; s < 400; s++) begin
      int len;
      @(negedge clk) raw_sensor = ~raw_sensor;
      if (raw_sensor && $urandom_range(0, 19) == 0) len = $urandom_range(190, 230);
      else len = $urandom_range(1, 14);
      repeat (len) @(negedge clk);
      if ($urandom_range(0, 49) == 0) begin
        #3 rst = 1'b0;
        #4 rst = 1'b1;
      end
    end

    @(negedge clk) raw_sensor = 1'b0;
    repeat (20) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vehicle_sensor.md
VEHICLE_SENSOR -- requirements
Module: vehicle_sensor

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYC, default 4: cycles the synchronized sensor must stay high before a vehicle is qualified (legal 1..255).
REQ-002 SHALL have parameter HOLD_CYC, default 8: cycles car_req is held after the synchronized sensor falls (legal 1..255).
REQ-003 SHALL have parameter STUCK_CYC, default 200: PRESENT-state cycles after which the sensor is declared stuck (legal 1..255).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port raw_sensor  input  1  asynchronous loop-detector input from the side road.
REQ-007 SHALL have port car_req  output  1  registered, debounced vehicle request; drives the controller's `in`.
REQ-008 SHALL have port det_pulse  output  1  registered one-cycle pulse per qualified vehicle.
REQ-009 SHALL have port fault  output  1  registered stuck-sensor flag.
REQ-010 SHALL have port car_count  output  8  count of qualified vehicles; see Configuration.

Function
REQ-011 SHALL synchronize raw_sensor through two flops (s1, s2); the FSM uses s2 only.
REQ-012 SHALL implement FSM states IDLE, QUAL, PRESENT, HOLD, FAULT, with one shared 8-bit cycle counter cnt.
REQ-013 IDLE: s2=1 -> QUAL, cnt=0; else stay.
REQ-014 QUAL: s2=0 -> IDLE; s2=1 and cnt==DEBOUNCE_CYC-1 -> PRESENT, cnt=0; else cnt+1.
REQ-015 PRESENT: s2=0 -> HOLD, cnt=0; s2=1 and cnt==STUCK_CYC-1 -> FAULT; else cnt+1.
REQ-016 HOLD: s2=1 -> PRESENT, cnt=0, with no new det_pulse; cnt==HOLD_CYC-1 -> IDLE; else cnt+1.
REQ-017 FAULT: s2=0 -> IDLE; else stay. Requalification is required after a fault.
REQ-018 car_req SHALL be 1 exactly when the registered state is PRESENT or HOLD.
REQ-019 fault SHALL be 1 exactly when the state is FAULT; car_req SHALL be 0 in FAULT.
REQ-020 det_pulse SHALL be 1 for the single cycle following the QUAL->PRESENT transition.
REQ-021 Latency: with raw held high, car_req SHALL rise at rising edge DEBOUNCE_CYC+3, counting the first edge that samples raw=1 as edge 1.
REQ-022 Latency: with raw held low from PRESENT, car_req SHALL fall at edge HOLD_CYC+3, counting the first edge that samples raw=0 as edge 1.
REQ-023 A raw pulse too short to reach PRESENT SHALL produce no car_req and no det_pulse.
REQ-024 Re-presence during HOLD SHALL keep car_req continuously high, with no glitch.

Reset
REQ-025 rst=0 SHALL immediately force s1, s2, cnt, car_count to 0, state to IDLE, and car_req, det_pulse, fault to 0, regardless of clk.
REQ-026 Reset asserted mid-operation (any state) SHALL abort that state; on release the FSM starts from IDLE and requires full requalification.

Configuration
REQ-027 Macro VEHICLE_SENSOR_COUNT_EN defined: car_count SHALL increment on each det_pulse and saturate at 255.
REQ-028 Macro VEHICLE_SENSOR_COUNT_EN undefined: car_count SHALL be constant 0, and no counter logic SHALL be present; all other behaviour is identical.

Verification (20 ns clock, default parameters)
REQ-029 rst=0 for 10 ns, with raw=1 -> all outputs 0 during reset; after release car_req rises at edge 7 with a one-cycle det_pulse.
REQ-030 raw high for 3 cycles, then low -> car_req, det_pulse, fault stay 0 throughout.
REQ-031 PRESENT, raw low for 4 cycles, then high -> car_req stays 1 with no second det_pulse; raw then low -> car_req falls at edge 11.
REQ-032 raw held high for 210 cycles -> fault=1 and car_req=0 after 200 PRESENT cycles; raw low -> fault clears 3 edges later, state IDLE.
REQ-033 rst pulsed low while in HOLD -> car_req drops asynchronously; after release with raw=1, requalification takes a full 7 edges.
REQ-034 With VEHICLE_SENSOR_COUNT_EN, 3 qualified vehicles -> car_count=3; forcing 260 vehicles -> car_count=255. Without the macro -> car_count=0.
